// File: rtl/fpga_exit_reporter.sv
// fpga_exit_reporter
// Captures the first exit event from x_heep_system, holds pass/fail status
// and blinks the low NUM_BITS of the exit code on one LED, MSB first:
//   preamble on 8u, off 4u, per bit on 3u/off 1u (one) or on 1u/off 3u (zero),
//   gap off 8u, repeat forever. u = BIT_CYCLES clocks.
// Optional watchdog: define FPGA_EXIT_REPORTER_WATCHDOG_EN to flag runs that
// never report an exit within TIMEOUT_CYCLES cycles of reset release.

module fpga_exit_reporter #(
    parameter int unsigned BIT_CYCLES     = 32'd12_500_000,
    parameter int unsigned NUM_BITS       = 32'd8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        done_o,
    output logic [31:0] exit_code_o,
    output logic        pass_o,
    output logic        fail_o,
    output logic        timeout_o,
    output logic        code_led_o
);

    localparam int unsigned CW = $clog2(32'd8 * BIT_CYCLES);
    localparam int unsigned IW = $clog2(NUM_BITS + 32'd1);

    // Counter reload values: a state lasting N cycles loads N-1 and leaves at zero.
    localparam logic [CW-1:0] DUR_8U  = CW'(32'd8 * BIT_CYCLES - 32'd1);
    localparam logic [CW-1:0] DUR_4U  = CW'(32'd4 * BIT_CYCLES - 32'd1);
    localparam logic [CW-1:0] DUR_3U  = CW'(32'd3 * BIT_CYCLES - 32'd1);
    localparam logic [CW-1:0] DUR_1U  = CW'(BIT_CYCLES - 32'd1);
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
    localparam logic [IW-1:0] IDX_TOP = IW'(NUM_BITS - 32'd1);
    localparam logic [IW-1:0] IDX_ONE = IW'(32'd1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_ON   = 3'd1,
        ST_PRE_OFF  = 3'd2,
        ST_BIT_ON   = 3'd3,
        ST_BIT_OFF  = 3'd4,
        ST_GAP      = 3'd5,
        ST_TIMEOUT  = 3'd6
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [IW-1:0] idx_r, idx_s;
    logic          done_r, done_s;
    logic [31:0]   code_r, code_s;
    logic          pass_r, pass_s;
    logic          fail_r, fail_s;
    logic          timeout_r, timeout_s;
    logic          led_r, led_s;

    logic          valid_r;
    logic          prev_r;
    logic [31:0]   value_r;
    logic          rise_s;
    logic          cnt_zero_s;
    logic          wd_hit_s;

    // Selects one bit of the captured code; uses every code bit so none dangle.
    function automatic logic code_bit(input logic [31:0] code, input logic [IW-1:0] idx);
        return |(code & (32'd1 << idx));
    endfunction

    // Registers the exit input and its previous sample for rising-edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
            prev_r  <= 1'b0;
            value_r <= 32'd0;
        end else begin
            valid_r <= exit_valid_i;
            prev_r  <= valid_r;
            value_r <= exit_value_i;
        end
    end

    assign rise_s     = valid_r & ~prev_r;
    assign cnt_zero_s = (cnt_r == '0);

`ifdef FPGA_EXIT_REPORTER_WATCHDOG_EN
    logic [31:0] wd_r;

    // Counts cycles spent in IDLE since reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_r <= 32'd0;
        end else if (state_r == ST_IDLE) begin
            wd_r <= wd_r + 32'd1;
        end else begin
            wd_r <= wd_r;
        end
    end

    assign wd_hit_s = (wd_r == (TIMEOUT_CYCLES - 32'd1));
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT_CYCLES;
    assign wd_hit_s         = 1'b0;
`endif

    // Next-state, duration reload, capture and LED drive decisions.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        done_s    = done_r;
        code_s    = code_r;
        pass_s    = pass_r;
        fail_s    = fail_r;
        timeout_s = timeout_r;
        led_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Capture beats a watchdog expiry landing on the same cycle.
                if (rise_s) begin
                    state_s = ST_PRE_ON;
                    cnt_s   = DUR_8U;
                    code_s  = value_r;
                    done_s  = 1'b1;
                    pass_s  = (value_r == 32'd0);
                    fail_s  = (value_r != 32'd0);
                end else if (wd_hit_s) begin
                    state_s   = ST_TIMEOUT;
                    cnt_s     = DUR_1U;
                    timeout_s = 1'b1;
                    fail_s    = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE_ON: begin
                if (cnt_zero_s) begin
                    state_s = ST_PRE_OFF;
                    cnt_s   = DUR_4U;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_PRE_OFF: begin
                if (cnt_zero_s) begin
                    state_s = ST_BIT_ON;
                    idx_s   = IDX_TOP;
                    cnt_s   = code_bit(code_r, IDX_TOP) ? DUR_3U : DUR_1U;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_BIT_ON: begin
                if (cnt_zero_s) begin
                    state_s = ST_BIT_OFF;
                    cnt_s   = code_bit(code_r, idx_r) ? DUR_1U : DUR_3U;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_BIT_OFF: begin
                if (!cnt_zero_s) begin
                    cnt_s = cnt_r - CNT_ONE;
                end else if (idx_r == '0) begin
                    state_s = ST_GAP;
                    cnt_s   = DUR_8U;
                end else begin
                    state_s = ST_BIT_ON;
                    idx_s   = idx_r - IDX_ONE;
                    cnt_s   = code_bit(code_r, idx_r - IDX_ONE) ? DUR_3U : DUR_1U;
                end
            end
            ST_GAP: begin
                if (cnt_zero_s) begin
                    state_s = ST_PRE_ON;
                    cnt_s   = DUR_8U;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_TIMEOUT: begin
                // Terminal until reset; the counter only paces the LED toggle.
                if (cnt_zero_s) begin
                    cnt_s = DUR_1U;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                idx_s   = '0;
            end
        endcase

        case (state_s)
            ST_PRE_ON, ST_BIT_ON: begin
                led_s = 1'b1;
            end
            ST_TIMEOUT: begin
                if (state_r != ST_TIMEOUT) begin
                    led_s = 1'b1;
                end else if (cnt_zero_s) begin
                    led_s = ~led_r;
                end else begin
                    led_s = led_r;
                end
            end
            default: begin
                led_s = 1'b0;
            end
        endcase
    end

    // State register plus all registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            idx_r     <= '0;
            done_r    <= 1'b0;
            code_r    <= 32'd0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
            led_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            idx_r     <= idx_s;
            done_r    <= done_s;
            code_r    <= code_s;
            pass_r    <= pass_s;
            fail_r    <= fail_s;
            timeout_r <= timeout_s;
            led_r     <= led_s;
        end
    end

    assign done_o      = done_r;
    assign exit_code_o = code_r;
    assign pass_o      = pass_r;
    assign fail_o      = fail_r;
    assign timeout_o   = timeout_r;
    assign code_led_o  = led_r;

endmodule

// File: tb/tb_fpga_exit_reporter.sv
// Scoreboard bench for fpga_exit_reporter (BIT_CYCLES=2, NUM_BITS=4,
// TIMEOUT_CYCLES=100). A reference model predicts every output after each
// clock edge and queues it; a monitor on the falling edge pops and compares.
`timescale 1ns/1ps

module tb_fpga_exit_reporter;

    localparam int unsigned BC = 32'd2;
    localparam int unsigned NB = 32'd4;
    localparam logic [31:0] TO = 32'd100;
    localparam int          FRAME = (8 + 4 + 4 * NB + 8) * BC;
`ifdef FPGA_EXIT_REPORTER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        done_o;
    logic [31:0] exit_code_o;
    logic        pass_o;
    logic        fail_o;
    logic        timeout_o;
    logic        code_led_o;

    fpga_exit_reporter #(
        .BIT_CYCLES     (BC),
        .NUM_BITS       (NB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .done_o       (done_o),
        .exit_code_o  (exit_code_o),
        .pass_o       (pass_o),
        .fail_o       (fail_o),
        .timeout_o    (timeout_o),
        .code_led_o   (code_led_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        done;
        logic [31:0] code;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic        led;
    } obs_t;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state, kept in terms of events rather than FSM states.
    bit          frame[$];
    bit          m_cap;
    bit          m_tmo;
    int          m_age;
    int          m_idle;
    logic [31:0] m_code;
    bit          m_v1, m_v2;
    logic [31:0] m_val1;

    // LED waveform of one full frame for a given code, one entry per cycle.
    function automatic void build_frame(input logic [31:0] c);
        int on;
        frame.delete();
        repeat (8 * BC) frame.push_back(1'b1);
        repeat (4 * BC) frame.push_back(1'b0);
        for (int b = NB - 1; b >= 0; b--) begin
            on = c[b] ? 3 : 1;
            repeat (on * BC)       frame.push_back(1'b1);
            repeat ((4 - on) * BC) frame.push_back(1'b0);
        end
        repeat (8 * BC) frame.push_back(1'b0);
    endfunction

    function automatic void model_reset();
        m_cap  = 1'b0;
        m_tmo  = 1'b0;
        m_age  = 0;
        m_idle = 0;
        m_code = 32'd0;
        m_v1   = 1'b0;
        m_v2   = 1'b0;
        m_val1 = 32'd0;
    endfunction

    // Model: after each rising clock edge predict the outputs and queue them.
    initial begin
        obs_t e;
        bit   rise;
        model_reset();
        forever begin
            @(posedge clk_i);
            e = '0;
            if (!rst_ni) begin
                model_reset();
            end else begin
                rise = m_v1 && !m_v2;
                if (!m_cap && !m_tmo) begin
                    m_idle++;
                    if (rise) begin
                        m_cap  = 1'b1;
                        m_code = m_val1;
                        m_age  = 0;
                        build_frame(m_val1);
                    end else if (WD && m_idle == int'(TO)) begin
                        m_tmo = 1'b1;
                        m_age = 0;
                    end
                end else begin
                    m_age++;
                end
                m_v2   = m_v1;
                m_v1   = exit_valid_i;
                m_val1 = exit_value_i;
                if (m_cap) begin
                    e.done = 1'b1;
                    e.code = m_code;
                    e.pass = (m_code == 32'd0);
                    e.fail = (m_code != 32'd0);
                    e.led  = frame[m_age % FRAME];
                end else if (m_tmo) begin
                    e.fail = 1'b1;
                    e.tmo  = 1'b1;
                    e.led  = ((m_age / BC) % 2) == 0;
                end
            end
            sb_q.push_back(e);
        end
    end

    // Monitor: on each falling edge pop the prediction and compare.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(negedge clk_i);
            g = '{done_o, exit_code_o, pass_o, fail_o, timeout_o, code_led_o};
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_empty t=%0t: no prediction queued, got %h", $time, g);
            end else begin
                e = sb_q.pop_front();
                // Reset is asynchronous: while held, every output must read 0.
                if (!rst_ni) e = '0;
                if (g === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs t=%0t got done=%b code=%h pass=%b fail=%b tmo=%b led=%b required done=%b code=%h pass=%b fail=%b tmo=%b led=%b",
                             $time, g.done, g.code, g.pass, g.fail, g.tmo, g.led,
                             e.done, e.code, e.pass, e.fail, e.tmo, e.led);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick(2);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        exit_valid_i = 1'b1;
        exit_value_i = $urandom;

        // Valid held high through reset: counts as an edge on the first clock.
        tick(4);
        rst_ni = 1'b1;
        tick(100);

        // Pass code, then a second edge with 0xDEAD that must be ignored.
        exit_valid_i = 1'b0;
        do_reset();
        tick(10);
        exit_value_i = 32'h0;
        exit_valid_i = 1'b1;
        tick(20);
        exit_valid_i = 1'b0;
        tick(30);
        exit_value_i = 32'h0000_DEAD;
        exit_valid_i = 1'b1;
        tick(5);
        exit_valid_i = 1'b0;
        tick(100);

        // Fail code 5: bits 0,1,0,1.
        do_reset();
        tick(3);
        exit_value_i = 32'h0000_0005;
        exit_valid_i = 1'b1;
        tick(3);
        exit_valid_i = 1'b0;
        tick(80);

        // Reset during the second bit, then a fresh capture of 3.
        exit_value_i = $urandom;
        exit_valid_i = 1'b1;
        do_reset();
        tick(1);
        exit_valid_i = 1'b0;
        tick(35);
        rst_ni = 1'b0;
        tick(2);
        rst_ni       = 1'b1;
        exit_value_i = 32'h0000_0003;
        exit_valid_i = 1'b1;
        tick(2);
        exit_valid_i = 1'b0;
        tick(80);

        // Long idle run, then a late edge (ignored if the watchdog fired).
        do_reset();
        tick(130);
        exit_value_i = $urandom;
        exit_valid_i = 1'b1;
        tick(3);
        exit_valid_i = 1'b0;
        tick(20);

        // Edge landing on the watchdog limit: capture wins.
        do_reset();
        tick(98);
        exit_value_i = $urandom;
        exit_valid_i = 1'b1;
        tick(4);
        exit_valid_i = 1'b0;
        tick(80);

        // Randomized runs with extra pulses and occasional mid-run reset.
        for (int it = 0; it < 10; it++) begin
            exit_valid_i = 1'b0;
            do_reset();
            tick($urandom_range(0, 15));
            exit_value_i = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            exit_valid_i = 1'b1;
            tick($urandom_range(1, 4));
            exit_valid_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick($urandom_range(5, 40));
                exit_value_i = $urandom;
                exit_valid_i = ~exit_valid_i;
                if ($urandom_range(0, 4) == 0) begin
                    rst_ni = 1'b0;
                    tick(1);
                    rst_ni = 1'b1;
                end
            end
            tick($urandom_range(20, 80));
        end

        exit_valid_i = 1'b0;
        tick(3);
        @(negedge clk_i);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpga_exit_reporter.md
# fpga_exit_reporter

Downstream consumer of the x_heep_system exit interface on FPGA boards. It captures the first exit event (`exit_valid` and the 32-bit `exit_value`) and holds pass/fail status. It then repeatedly blinks the low bits of the exit code on a single LED pin, so a board-level run can be judged without JTAG or UART. An optional watchdog flags runs that never report an exit.

## Interface
- `BIT_CYCLES`, default 12_500_000: base time unit in `clk_i` cycles; legal range ≥1.
- `NUM_BITS`, default 8: number of exit-code LSBs blinked, sent MSB first; legal range 1..32.
- `TIMEOUT_CYCLES`, default 32'd2_000_000_000: watchdog limit in cycles; used only when the watchdog macro is defined.
- `clk_i`  in  1  system clock; same domain as the x_heep_system `clk_i`.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `exit_valid_i`  in  1  exit valid from x_heep_system.
- `exit_value_i`  in  32  exit value from x_heep_system.
- `done_o`  out  1  exit captured; sticky until reset.
- `exit_code_o`  out  32  captured exit value.
- `pass_o`  out  1  captured value == 0.
- `fail_o`  out  1  captured value != 0, or watchdog expired.
- `timeout_o`  out  1  watchdog expired.
- `code_led_o`  out  1  blink-code LED drive.

## Operation
- Reset values: every output is 0, and the FSM is in IDLE.
- Edge detect: a registered copy of `exit_valid_i` resets to 0. A rising edge is current=1 and previous=0, so an input already high at reset release counts as an edge on the first clock.
- Capture happens only in IDLE. On a rising edge:
  - latch `exit_value_i` into `exit_code_o`;
  - set `done_o`, and set `pass_o` or `fail_o`;
  - go to PREAMBLE.
- After capture, all later `exit_valid_i` activity is ignored until reset.
- FSM states: IDLE, PREAMBLE_ON, PREAMBLE_OFF, BIT_ON, BIT_OFF, GAP, TIMEOUT. A time unit `u` is `BIT_CYCLES` cycles.
- PREAMBLE_ON: LED on for 8u, then PREAMBLE_OFF.
- PREAMBLE_OFF: LED off for 4u, then BIT_ON with the bit index at `NUM_BITS`-1.
- Bit symbol (4u total):
  - bit=0: BIT_ON 1u, then BIT_OFF 3u;
  - bit=1: BIT_ON 3u, then BIT_OFF 1u.
- After the BIT_OFF of bit 0, go to GAP: LED off 8u, then PREAMBLE_ON. The code repeats forever.
- `code_led_o` is a registered output: it is high exactly in PREAMBLE_ON and BIT_ON, and toggles every u in TIMEOUT.
- Counters:
  - duration counter width is `$clog2(8*BIT_CYCLES)`; it reloads on each state entry;
  - bit index width is `$clog2(NUM_BITS+1)`.
- Reset mid-operation aborts immediately and asynchronously: all outputs go to 0, and a new capture is possible after release.

## Timing
- A rising edge sampled at clock edge N makes `done_o`, `exit_code_o`, `pass_o`/`fail_o` and `code_led_o`=1 visible after edge N+1. Capture latency is 1 cycle.
- Every state lasts exactly its stated multiple of `BIT_CYCLES` clocks, with no extra transition cycles.
- One full frame is (8+4+4·NUM_BITS+8)·u cycles.
- Watchdog limit and capture in the same cycle: capture wins, and `timeout_o` stays 0.
- There is no handshake back to x_heep_system; the input is sampled only.

## Configuration
- Macro: `FPGA_EXIT_REPORTER_WATCHDOG_EN`.
- Defined:
  - a 32-bit counter counts cycles in IDLE from reset release;
  - when it reaches `TIMEOUT_CYCLES` with no capture, go to TIMEOUT and set `timeout_o`=1 and `fail_o`=1;
  - `code_led_o` toggles every u; `exit_code_o` stays 0 and `done_o` stays 0;
  - TIMEOUT is terminal until reset.
- Not defined:
  - no counter logic; `timeout_o` is tied 0;
  - `TIMEOUT_CYCLES` is ignored;
  - the block waits in IDLE indefinitely.

## Test plan
Bench parameters: `BIT_CYCLES`=2, `NUM_BITS`=4, `TIMEOUT_CYCLES`=100.
- Reset: hold `rst_ni`=0 while `exit_valid_i`=1 → all outputs 0. Release → `done_o`=1 one cycle after the first clock.
- Pass: value 0x0, valid rises at cycle 10 → from cycle 11, `pass_o`=1 and `exit_code_o`=0. LED sequence: high 16, low 8, then 4×(high 2, low 6), then low 16, then repeats.
- Fail: value 0x0000_0005 → `fail_o`=1. Bits 0,1,0,1 blink as (high 2, low 6), (high 6, low 2), (high 2, low 6), (high 6, low 2).
- Sticky: a second valid edge with 0xDEAD → `exit_code_o` stays at the first value and the frame is uninterrupted.
- Watchdog (macro on): no valid → `timeout_o`=1, `fail_o`=1 at cycle 100, then LED toggles every 2 cycles; a later valid edge is ignored. Valid at cycle 100 → capture, `timeout_o`=0.
- Mid-run reset: assert `rst_ni` during the second bit → all outputs 0 at once. Release, then value 0x3 → new frame with code 0011.
